sys_arr_fp_add_lanes: RTL
=========================

// Module: sys_arr_fp_add_lanes
// PURPOSE
//  Multi-lane, multi-cycle floating-point adder for the tensor-core systolic array accumulate path.
//  Generalises the single-operand start/value_ready adder to LANES independent lanes.
//  Element format is configurable as sign/EXP_W/MAN_W.
//  A shared FSM sequences all lanes in lock-step.
//  Sits between the array column outputs and the partial-sum buffer.
// PARAMETERS
//  EXP_W  5    exponent field width (bias = 2^(EXP_W-1)-1)
//  MAN_W  10   stored mantissa width (hidden bit implicit)
//  LANES  4    number of parallel adds issued per start
//  DW     derived 1+EXP_W+MAN_W (local, not overridable); default 16 = IEEE half
// PORTS
//  clk          in   1         rising-edge clock
//  nRST         in   1         asynchronous, active-low reset
//  start        in   1         issue request; sampled only when value_ready=1
//  add_input1   in   LANES*DW  operand A; lane i occupies bits [i*DW +: DW]
//  add_input2   in   LANES*DW  operand B, same packing as add_input1
//  add_output   out  LANES*DW  sum per lane; holds last result until overwritten
//  value_ready  out  1         1 when IDLE (can accept start)
//  out_valid    out  1         one-cycle pulse when add_output updated
// BEHAVIOUR
//  FSM IDLE->ALIGN->ADD->NORM->IDLE:
//   - exactly one state per clock; leaves IDLE only on start&value_ready
//   - IDLE: operands captured into registers on the start edge
//   - ALIGN: unpack, flush denormals, swap so |A|>=|B|, right-shift smaller mantissa by exp diff
//     (keep >= 1 guard bit, shift saturates at MAN_W+2)
//   - ADD: signed mantissa add/subtract by sign compare, MAN_W+2 bits
//   - NORM: leading-one normalise, exponent adjust, pack; add_output written on NORM->IDLE edge
//  Timing: start sampled at edge T; add_output valid and out_valid=1 in cycle after edge T+3.
//   - value_ready=0 after edges T..T+2, 1 again after edge T+3
//   - next start accepted at edge T+4: latency 3, issue interval 4
//  start while value_ready=0: ignored, no state or data effect; inputs only sampled at the accepting edge.
//  value_ready = (state==IDLE), combinational from state register.
//  Arithmetic, per lane, independent:
//   - rounding: truncate (round toward zero)
//   - denormal inputs treated as zero; denormal results flushed to signed zero
//   - exponent overflow -> +/-inf (exp all ones, man 0)
//   - exact cancellation -> +0
//   - NaN in, or inf + -inf -> canonical qNaN {0, all-ones exp, 1'b1, zeros}
//   - inf + finite -> that inf
//  Reset (async, nRST=0), including mid-operation:
//   - state=IDLE, add_output=0, out_valid=0, value_ready=1
//   - in-flight op discarded, no out_valid after release
// CONFIGURATION
//  SYS_ARR_ADD_SUB_EN defined:
//   - extra port: sub  in  LANES  per-lane subtract, sampled with start
//   - lane i computes A-B (B sign inverted at capture); NaN/inf rules apply after inversion
//  SYS_ARR_ADD_SUB_EN undefined: no sub port; all lanes compute A+B.
//  Latency, handshake and reset identical in both builds.
// TESTING
//  1. Lane0 0x3C00+0x3C00, lane1 0x3C00+0x4000, start at edge 0:
//     out_valid high only in cycle after edge 3, lane0 0x4000, lane1 0x4200;
//     value_ready low after edges 0..2.
//  2. Special values: 0x3C00+0xBC00 -> 0x0000; 0x7BFF+0x7BFF -> 0x7C00;
//     0x7C00+0xFC00 -> 0x7E00; 0x0001+0x0000 -> 0x0000.
//  3. Truncation: 0x3C00+0x1000 (1+2^-11) -> 0x3C00; 0x4000+0x3C00 -> 0x4200.
//  4. Busy/back-to-back:
//     - start with new data at edges 0..3: only edge-0 data produces a result, one pulse
//     - held start at edge 4 issues a second op with out_valid after edge 7
//  5. Reset mid-op: assert nRST=0 after edge 1 of an op;
//     outputs 0, value_ready=1 immediately; no out_valid after release.
//  6. SYS_ARR_ADD_SUB_EN build: sub=4'b0101, all lanes 0x4200 op 0x3C00 ->
//     lanes0,2 0x4000; lanes1,3 0x4400.

Source files
------------

// File: rtl/sys_arr_fp_add_lanes.sv
// Lock-step multi-lane floating-point adder (sign/EXP_W/MAN_W), IDLE->ALIGN->ADD->NORM, truncating.
// Optional per-lane subtract: define SYS_ARR_ADD_SUB_EN to add the `sub` port.

module sys_arr_fp_add_lane #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 cap,
  input  logic                 align_en,
  input  logic                 add_en,
  input  logic                 norm_en,
  input  logic                 neg,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] res
);
  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int FW = EXP_W + MAN_W;
  localparam int EW = MAN_W + 4;  // hidden + mantissa + guard/round/sticky
  localparam int SH_MAX = MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic [DW-1:0]    a_q, b_q;
  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, spec, swap, sticky;
  logic [FW-1:0]    fa, fb, fbig, fsml;
  logic [EW-1:0]    mbig, msml, mask, mal;
  logic [EXP_W-1:0] diff;
  logic [DW-1:0]    spec_val;
  int               sh;

  logic [EW-1:0]    mb_r, ms_r;
  logic [EXP_W-1:0] eb_r;
  logic             sb_r, subop_r, spec_r;
  logic [DW-1:0]    specv_r;
  logic [EW:0]      sum_r;

  int               p, e_res;
  logic [EW:0]      norm;
  logic [DW-1:0]    nv;

  always_comb begin
    sa    = a_q[DW-1];
    sb    = b_q[DW-1];
    a_nan = (a_q[FW-1 -: EXP_W] == EXP_ONES) && (|a_q[MAN_W-1:0]);
    b_nan = (b_q[FW-1 -: EXP_W] == EXP_ONES) && (|b_q[MAN_W-1:0]);
    a_inf = (a_q[FW-1 -: EXP_W] == EXP_ONES) && !(|a_q[MAN_W-1:0]);
    b_inf = (b_q[FW-1 -: EXP_W] == EXP_ONES) && !(|b_q[MAN_W-1:0]);
    spec  = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      spec_val = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    else if (a_inf)
      spec_val = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else
      spec_val = {sb, EXP_ONES, {MAN_W{1'b0}}};
    // denormals flushed; exp/man field compare equals magnitude compare
    fa   = (a_q[FW-1 -: EXP_W] == '0) ? '0 : a_q[FW-1:0];
    fb   = (b_q[FW-1 -: EXP_W] == '0) ? '0 : b_q[FW-1:0];
    swap = fb > fa;
    fbig = swap ? fb : fa;
    fsml = swap ? fa : fb;
    mbig = (fbig[FW-1 -: EXP_W] == '0) ? '0 : {1'b1, fbig[MAN_W-1:0], 3'b000};
    msml = (fsml[FW-1 -: EXP_W] == '0) ? '0 : {1'b1, fsml[MAN_W-1:0], 3'b000};
    diff = fbig[FW-1 -: EXP_W] - fsml[FW-1 -: EXP_W];
    sh   = (int'(diff) > SH_MAX) ? SH_MAX : int'(diff);
    // sticky keeps truncation exact for subtraction
    mask   = ~({EW{1'b1}} << sh);
    sticky = |(msml & mask);
    mal    = (msml >> sh) | {{(EW-1){1'b0}}, sticky};
  end

  always_comb begin
    p = 0;
    for (int i = 0; i <= EW; i++)
      if (sum_r[i]) p = i;
    e_res = int'(eb_r) + p - (EW - 1);
    norm  = sum_r << (EW - p);
    if (spec_r)                       nv = specv_r;
    else if (sum_r == '0)             nv = '0;
    else if (e_res >= int'(EXP_ONES)) nv = {sb_r, EXP_ONES, {MAN_W{1'b0}}};
    else if (e_res <= 0)              nv = {sb_r, {FW{1'b0}}};
    else                              nv = {sb_r, e_res[EXP_W-1:0], norm[EW-1 -: MAN_W]};
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      a_q     <= '0;
      b_q     <= '0;
      mb_r    <= '0;
      ms_r    <= '0;
      eb_r    <= '0;
      sb_r    <= 1'b0;
      subop_r <= 1'b0;
      spec_r  <= 1'b0;
      specv_r <= '0;
      sum_r   <= '0;
      res     <= '0;
    end else begin
      if (cap) begin
        a_q <= a;
        b_q <= {b[DW-1] ^ neg, b[DW-2:0]};
      end
      if (align_en) begin
        mb_r    <= mbig;
        ms_r    <= mal;
        eb_r    <= fbig[FW-1 -: EXP_W];
        sb_r    <= swap ? sb : sa;
        subop_r <= sa ^ sb;
        spec_r  <= spec;
        specv_r <= spec_val;
      end
      if (add_en)
        sum_r <= subop_r ? ({1'b0, mb_r} - {1'b0, ms_r}) : ({1'b0, mb_r} + {1'b0, ms_r});
      if (norm_en)
        res <= nv;
    end
  end
endmodule

module sys_arr_fp_add_lanes #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int LANES = 4
) (
  input  logic                               clk,
  input  logic                               nRST,
  input  logic                               start,
`ifdef SYS_ARR_ADD_SUB_EN
  input  logic [LANES-1:0]                   sub,
`endif
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]   add_input1,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]   add_input2,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0]   add_output,
  output logic                               value_ready,
  output logic                               out_valid
);
  localparam int DW = 1 + EXP_W + MAN_W;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;
  state_t state, state_nxt;
  logic cap, align_en, add_en, norm_en;
  logic [LANES-1:0] neg;

`ifdef SYS_ARR_ADD_SUB_EN
  assign neg = sub;
`else
  assign neg = '0;
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    value_ready = (state == IDLE);
    cap         = (state == IDLE) && start;
    align_en    = (state == ALIGN);
    add_en      = (state == ADD);
    norm_en     = (state == NORM);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) out_valid <= 1'b0;
    else       out_valid <= norm_en;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sys_arr_fp_add_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane (
      .clk      (clk),
      .nRST     (nRST),
      .cap      (cap),
      .align_en (align_en),
      .add_en   (add_en),
      .norm_en  (norm_en),
      .neg      (neg[i]),
      .a        (add_input1[i*DW +: DW]),
      .b        (add_input2[i*DW +: DW]),
      .res      (add_output[i*DW +: DW])
    );
  end
endmodule
